regbank_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares the single write/read port of the 16-register ALU register bank between two requesters: the AXI4-Lite slave front end and a local command source. It serialises one transaction at a time. It drives the bank's write/read address and data, captures read data into a registered response, and rejects illegal accesses (writes to read-only word 3, unaligned addresses) without touching the bank.

---
 rtl/regbank_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_regbank_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_arbiter.sv
// regbank_arbiter
//   Two-requester round-robin arbiter/sequencer in front of the single
//   write/read port of the 16-register ALU bank. One transaction in flight:
//   IDLE (accept) -> ISSUE (drive bank) -> RESP (hold response until taken).
//   Writes to the read-only word RO_INDEX and unaligned addresses are
//   rejected with rsp_err and never reach the bank.
//
//   Optional feature macro: REGARB_RSP_TIMEOUT_EN
//     defined   : response is dropped after TIMEOUT_CYCLES RESP cycles
//                 without a handshake; timeout pulses for one cycle.
//     undefined : timeout tied low, RESP waits indefinitely.
//
//   Ports
//     clk, reset_n                     clock, asynchronous active-low reset
//     req_valid/ready/write [1:0]      request handshake per requester
//                                      (0 = AXI side, 1 = local)
//     req_addr/req_wdata [1:0][31:0]   byte address / write data per requester
//     rsp_valid/ready [1:0]            response handshake to owning requester
//     rsp_rdata [31:0], rsp_err        registered response payload
//     timeout                          one-cycle pulse on a dropped response
//     busy                             high in ISSUE and RESP
//     bank_write_en/addr/data          bank write port
//     bank_read_addr, bank_read_data   bank combinational read port
module regbank_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned RO_INDEX       = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_write,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             timeout,
  output logic             busy,
  output logic             bank_write_en,
  output logic [31:0]      bank_write_addr,
  output logic [31:0]      bank_write_data,
  output logic [31:0]      bank_read_addr,
  input  logic [31:0]      bank_read_data
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || RO_INDEX > 15) begin : g_param_check
    $error("regbank_arbiter: TIMEOUT_CYCLES must be 2..65535 and RO_INDEX 0..15");
  end

  localparam logic [3:0] RO_IDX4 = 4'(RO_INDEX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_last;       // requester served most recently
  logic        r_owner;
  logic        r_write;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_bank_we;
  logic [1:0]  r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic [1:0]  w_grant;
  logic        w_sel;
  logic        w_accept;
  logic        w_req_err;
  logic        w_hs;
  logic        w_tmo;

  // Round-robin: on a tie the requester that was not served last wins.
  always_comb begin
    w_grant = '0;
    case (req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
      default: w_grant = '0;
    endcase
  end

  assign w_sel     = w_grant[1];
  assign req_ready = ((r_state == S_IDLE) && reset_n) ? w_grant : '0;
  assign w_accept  = |req_ready;
  assign w_req_err = (req_addr[w_sel][1:0] != 2'b00) ||
                     (req_write[w_sel] && (req_addr[w_sel][5:2] == RO_IDX4));
  assign w_hs      = |(r_rsp_valid & rsp_ready);

`ifdef REGARB_RSP_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_tcnt;
  logic        r_timeout;

  // Counter equals the number of completed RESP cycles; the drop happens at
  // the end of the TIMEOUT_CYCLES-th one unless a handshake lands there.
  assign w_tmo = (r_state == S_RESP) && !w_hs && (r_tcnt == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_tcnt <= '0;
      end else if (r_state == S_RESP && !w_hs) begin
        r_tcnt <= r_tcnt + 16'd1;
      end
      r_timeout <= w_tmo;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_tmo   = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP:  if (w_hs || w_tmo) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_bank_we   <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      // Write strobe is set by the accepting edge and cleared by the next
      // one, so it covers exactly the ISSUE cycle.
      if (w_accept) begin
        r_last    <= w_sel;
        r_owner   <= w_sel;
        r_write   <= req_write[w_sel];
        r_err     <= w_req_err;
        r_addr    <= req_addr[w_sel];
        r_wdata   <= req_wdata[w_sel];
        r_bank_we <= req_write[w_sel] && !w_req_err;
      end else begin
        r_bank_we <= 1'b0;
      end

      if (r_state == S_ISSUE) begin
        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
        r_rsp_rdata <= (!r_write && !r_err) ? bank_read_data : '0;
        r_rsp_err   <= r_err;
      end else if (r_state == S_RESP && (w_hs || w_tmo)) begin
        r_rsp_valid <= '0;
      end
    end
  end

  assign busy            = (r_state != S_IDLE);
  assign bank_write_en   = r_bank_we;
  assign bank_write_addr = r_addr;
  assign bank_read_addr  = r_addr;
  assign bank_write_data = r_wdata;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_rdata       = r_rsp_rdata;
  assign rsp_err         = r_rsp_err;

endmodule

// File: tb/tb_regbank_arbiter.sv
module tb_regbank_arbiter;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_write;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             timeout;
  logic             busy;
  logic             bank_write_en;
  logic [31:0]      bank_write_addr;
  logic [31:0]      bank_write_data;
  logic [31:0]      bank_read_addr;
  logic [31:0]      bank_read_data;

  regbank_arbiter #(
    .TIMEOUT_CYCLES(256),
    .RO_INDEX      (3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .timeout        (timeout),
    .busy           (busy),
    .bank_write_en  (bank_write_en),
    .bank_write_addr(bank_write_addr),
    .bank_write_data(bank_write_data),
    .bank_read_addr (bank_read_addr),
    .bank_read_data (bank_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bank_rd;
    logic        exp_we;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  localparam int unsigned NVEC = 10;

  vec_t vecs[NVEC];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with the bus idle.
  task automatic do_txn(input vec_t v);
    int unsigned waited;
    exp_t        e;
    req_valid[v.port] = 1'b1;
    req_write[v.port] = v.write;
    req_addr[v.port]  = v.addr;
    req_wdata[v.port] = v.wdata;
    bank_read_data    = v.bank_rd;
    sb.push_back('{valid: (v.port ? 2'b10 : 2'b01),
                   rdata: v.exp_rdata, err: v.exp_err});
    #1;
    waited = 0;
    while (!req_ready[v.port] && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!req_ready[v.port]) begin
      check("accept_wait", 32'(req_ready), 32'(v.port ? 2'b10 : 2'b01));
      req_valid[v.port] = 1'b0;
      void'(sb.pop_back());
      @(negedge clk);
      return;
    end
    @(negedge clk);
    check("issue_busy", 32'(busy), 32'd1);
    check("issue_we", 32'(bank_write_en), 32'(v.exp_we));
    check("issue_waddr", bank_write_addr, v.addr);
    check("issue_raddr", bank_read_addr, v.addr);
    check("issue_wdata", bank_write_data, v.wdata);
    check("issue_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid[v.port] = 1'b0;
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("rsp_valid", 32'(rsp_valid), 32'(e.valid));
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_err", 32'(rsp_err), 32'(e.err));
    end
    check("resp_we_low", 32'(bank_write_en), 32'd0);
    rsp_ready[v.port] = 1'b1;
    @(negedge clk);
    check("post_hs_valid", 32'(rsp_valid), 32'd0);
    check("post_hs_busy", 32'(busy), 32'd0);
    rsp_ready = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          acc_port[4];
    int          acc_cyc[4];
    int          nacc;
    int          vcnt;
    int          tcnt;
    int unsigned waited;

    vecs[0] = '{1'b0, 1'b1, 32'h04, 32'h12,       32'h99,       1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0C, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'h0C, 32'h33,       32'h0,        1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 32'h02, 32'h44,       32'h0,        1'b0, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h4C, 32'h55,       32'h0,        1'b0, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h03, 32'h0,        32'h1234,     1'b0, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 32'h3C, 32'hCAFEF00D, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 32'h08, 32'h77,       32'h0,        1'b1, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 32'h00, 32'h0,        32'h0BADF00D, 1'b0, 1'b0, 32'h0BADF00D};
    vecs[9] = '{1'b1, 1'b0, 32'h3E, 32'h0,        32'hFFFF,     1'b0, 1'b1, 32'h0};

    // Reset state, with requests asserted to show ready is gated by reset.
    reset_n        = 1'b0;
    req_valid      = 2'b11;
    req_write      = '0;
    req_addr       = '0;
    req_wdata      = '0;
    rsp_ready      = '0;
    bank_read_data = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(bank_write_en), 32'd0);
    check("rst_waddr", bank_write_addr, 32'd0);
    check("rst_wdata", bank_write_data, 32'd0);
    check("rst_raddr", bank_read_addr, 32'd0);
    req_valid = '0;
    reset_n   = 1'b1;
    @(negedge clk);

    for (int i = 0; i < int'(NVEC); i++) begin
      do_txn(vecs[i]);
    end

    // A request withdrawn before any rising edge is never accepted.
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 32'h10;
    #2;
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("withdraw_busy", 32'(busy), 32'd0);
    check("withdraw_we", 32'(bank_write_en), 32'd0);

    // Round robin from reset: both valid, responses always taken.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n      = 1'b1;
    req_write    = 2'b01;
    req_addr[0]  = 32'h10;
    req_addr[1]  = 32'h14;
    req_wdata[0] = 32'hA0;
    req_valid    = 2'b11;
    rsp_ready    = 2'b11;
    nacc         = 0;
    #1;
    for (int c = 0; c < 40 && nacc < 4; c++) begin
      if (req_ready != 2'b00) begin
        if (req_ready == 2'b11) check("rr_onehot", 32'(req_ready), 32'd1);
        acc_port[nacc] = req_ready[1] ? 1 : 0;
        acc_cyc[nacc]  = c;
        nacc++;
      end
      if (nacc < 4) begin
        @(negedge clk);
        #1;
      end
    end
    check("rr_count", 32'(nacc), 32'd4);
    for (int k = 0; k < 4 && k < nacc; k++) begin
      check("rr_port", 32'(acc_port[k]), 32'(k % 2));
      if (k > 0) check("rr_gap", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rsp_ready = '0;
    check("rr_idle", 32'(busy), 32'd0);

    // Response held with rsp_ready low for 300 cycles.
    req_valid[0]   = 1'b1;
    req_write[0]   = 1'b0;
    req_addr[0]    = 32'h00;
    bank_read_data = 32'hA5A5;
    #1;
    waited = 0;
    while (!req_ready[0] && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("to_accept", 32'(req_ready[0]), 32'd1);
    vcnt = 0;
    tcnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      req_valid[0] = 1'b0;
      if (rsp_valid[0]) vcnt++;
      if (timeout) tcnt++;
    end
`ifdef REGARB_RSP_TIMEOUT_EN
    check("to_valid_cycles", 32'(vcnt), 32'd256);
    check("to_pulses", 32'(tcnt), 32'd1);
    check("to_dropped", 32'(rsp_valid), 32'd0);
    do_txn(vecs[1]);
`else
    check("hold_valid_cycles", 32'(vcnt), 32'd299);
    check("hold_pulses", 32'(tcnt), 32'd0);
    check("hold_valid", 32'(rsp_valid), 32'd1);
    check("hold_rdata", rsp_rdata, 32'hA5A5);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("hold_release", 32'(rsp_valid), 32'd0);
    rsp_ready = '0;
`endif

    // Reset asserted during the ISSUE cycle of a legal write.
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h08;
    req_wdata[0] = 32'h55;
    #1;
    waited = 0;
    while (!req_ready[0] && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    @(negedge clk);
    check("rsti_we_before", 32'(bank_write_en), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rsti_we", 32'(bank_write_en), 32'd0);
    check("rsti_busy", 32'(busy), 32'd0);
    check("rsti_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rsti_ready", 32'(req_ready), 32'd0);
    check("rsti_waddr", bank_write_addr, 32'd0);
    check("rsti_rdata", rsp_rdata, 32'd0);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rsti_no_partial", 32'(rsp_valid), 32'd0);
    do_txn(vecs[8]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
